// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS control unit:
//   - stateT     : FSM state encoding with fixed 4-bit codes
//   - OP_*       : instruction opcodes (InstrReg[31:26])
//   - FUNCT_*    : R-type function codes (InstrReg[5:0])
//   - ALU_*      : ALUControl operation codes
//   - isWaitState: states that sit on the memory handshake
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd15
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // The watchdog only watches states that wait on the memory handshake.
  function automatic logic isWaitState(input stateT s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm_if
// Bundle between the control unit and the datapath/memory.
//   master : the control unit (takes op/funct/zero/mem_ready, drives selects)
//   slave  : the datapath side (drives op/funct/zero/mem_ready, takes selects)
// Parameters STATE_W and ALUCTL_W size the debug state and ALUControl fields.
// ---------------------------------------------------------------------------
interface mc_ctrl_fsm_if #(
  parameter int STATE_W  = 4,
  parameter int ALUCTL_W = 3
);

  logic [5:0]          op;
  logic [5:0]          funct;
  logic                zero;
  logic                mem_ready;
  logic                mem_req;
  logic                IRWrite;
  logic                RegDst;
  logic                MemtoReg;
  logic                RegWrite;
  logic                ALUSrcA;
  logic                MemWrite;
  logic                PCEn;
  logic [1:0]          ALUSrcB;
  logic [1:0]          PCSrc;
  logic [ALUCTL_W-1:0] ALUControl;
  logic [STATE_W-1:0]  p_state;
  logic                illegal;
  logic                timeout;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, MemWrite,
           PCEn, ALUSrcB, PCSrc, ALUControl, p_state, illegal, timeout
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, MemWrite,
           PCEn, ALUSrcB, PCSrc, ALUControl, p_state, illegal, timeout
  );

endinterface

// File: rtl/mc_alu_decoder.sv
// ---------------------------------------------------------------------------
// mc_alu_decoder
// Combinational R-type decoder.
//   i_funct        : InstrReg[5:0]
//   o_aluControl   : ALU operation for the decoded funct (000 when unknown)
//   o_functIllegal : funct is not one of add/sub/and/or/slt
// ---------------------------------------------------------------------------
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_aluControl,
  output logic       o_functIllegal
);

  // Map each supported funct onto its ALU code; anything else is flagged so
  // the FSM can halt instead of executing garbage.
  always_comb begin
    o_aluControl   = 3'b000;
    o_functIllegal = 1'b0;
    case (i_funct)
      FUNCT_ADD: o_aluControl = ALU_ADD;
      FUNCT_SUB: o_aluControl = ALU_SUB;
      FUNCT_AND: o_aluControl = ALU_AND;
      FUNCT_OR:  o_aluControl = ALU_OR;
      FUNCT_SLT: o_aluControl = ALU_SLT;
      default:   o_functIllegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
// Multicycle MIPS control unit with memory handshake, stall watchdog and
// sticky illegal-instruction halt.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : mc_ctrl_fsm_if.master (op, funct, zero, mem_ready in; datapath
//           selects, mem_req, p_state, illegal, timeout out)
// Parameters: STATE_W (>=4), MEM_HANDSHAKE (1 waits on mem_ready),
// TIMEOUT_CYCLES (0 disables watchdog), ALUCTL_W (3 only).
// ---------------------------------------------------------------------------
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W        = 4,
  parameter int MEM_HANDSHAKE  = 1,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ALUCTL_W       = 3
) (
  input  logic          clk,
  input  logic          reset,
  mc_ctrl_fsm_if.master bus
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (TIMEOUT_CYCLES > 0) ? WAIT_W'(TIMEOUT_CYCLES - 1) : '0;

  stateT             r_state;
  logic [WAIT_W-1:0] r_waitCnt;
  logic              r_illegal;
  logic              r_timeout;

  logic       w_rdy;
  logic       w_stallExpired;
  logic [2:0] w_functAluCtl;
  logic       w_functIllegal;

  logic       w_memReq, w_irWrite, w_regDst, w_memtoReg, w_regWrite;
  logic       w_aluSrcA, w_memWrite, w_pcWrite, w_branch, w_branchNe;
  logic       w_pcEn;
  logic [1:0] w_aluSrcB, w_pcSrc;
  logic [2:0] w_aluCtl;

  assign w_rdy = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;

  // A stall of exactly TIMEOUT_CYCLES cycles trips the watchdog; a ready in
  // that same last cycle still lets the access complete.
  assign w_stallExpired = (TIMEOUT_CYCLES != 0) && isWaitState(r_state) &&
                          !w_rdy && (r_waitCnt == WAIT_LAST);

  mc_alu_decoder u_aluDecoder (
    .i_funct        (bus.funct),
    .o_aluControl   (w_functAluCtl),
    .o_functIllegal (w_functIllegal)
  );

  // State register, watchdog counter and sticky error flags. The counter only
  // runs while a wait state is stalled; every transition (including entry to
  // a wait state) and every ready cycle leaves it at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_waitCnt <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (isWaitState(r_state) && !w_rdy && !w_stallExpired)
        r_waitCnt <= r_waitCnt + WAIT_W'(1);
      else
        r_waitCnt <= '0;

      case (r_state)
        S_FETCH: begin
          if (w_stallExpired) begin
            r_state   <= S_HALT;
            r_timeout <= 1'b1;
          end else if (w_rdy) begin
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (bus.op)
            OP_LW, OP_SW:   r_state <= S_MEMADR;
            OP_RTYPE:       r_state <= S_EXEC;
            OP_BEQ, OP_BNE: r_state <= S_BRANCH;
            OP_ADDI:        r_state <= S_ADDIEX;
            OP_J:           r_state <= S_JUMP;
            default: begin
              r_state   <= S_HALT;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADR: r_state <= (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD: begin
          if (w_stallExpired) begin
            r_state   <= S_HALT;
            r_timeout <= 1'b1;
          end else if (w_rdy) begin
            r_state <= S_MEMWB;
          end
        end
        S_MEMWB: r_state <= S_FETCH;
        S_MEMWR: begin
          if (w_stallExpired) begin
            r_state   <= S_HALT;
            r_timeout <= 1'b1;
          end else if (w_rdy) begin
            r_state <= S_FETCH;
          end
        end
        S_EXEC: begin
          if (w_functIllegal) begin
            r_state   <= S_HALT;
            r_illegal <= 1'b1;
          end else begin
            r_state <= S_ALUWB;
          end
        end
        S_ALUWB:  r_state <= S_FETCH;
        S_BRANCH: r_state <= S_FETCH;
        S_ADDIEX: r_state <= S_ADDIWB;
        S_ADDIWB: r_state <= S_FETCH;
        S_JUMP:   r_state <= S_FETCH;
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_HALT;
      endcase
    end
  end

  // Moore decode of the datapath selects from the current state. Only the
  // write strobes look at mem_ready, so a stalled access never commits.
  always_comb begin
    w_memReq   = 1'b0;
    w_irWrite  = 1'b0;
    w_regDst   = 1'b0;
    w_memtoReg = 1'b0;
    w_regWrite = 1'b0;
    w_aluSrcA  = 1'b0;
    w_memWrite = 1'b0;
    w_pcWrite  = 1'b0;
    w_branch   = 1'b0;
    w_branchNe = 1'b0;
    w_aluSrcB  = 2'b00;
    w_pcSrc    = 2'b00;
    w_aluCtl   = 3'b000;
    case (r_state)
      S_FETCH: begin
        w_memReq  = 1'b1;
        w_aluSrcB = 2'b01;
        w_aluCtl  = ALU_ADD;
        w_irWrite = w_rdy;
        w_pcWrite = w_rdy;
      end
      S_DECODE: begin
        w_aluSrcB = 2'b11;
        w_aluCtl  = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        w_aluSrcA = 1'b1;
        w_aluSrcB = 2'b10;
        w_aluCtl  = ALU_ADD;
      end
      S_MEMRD: w_memReq = 1'b1;
      S_MEMWB: begin
        w_memtoReg = 1'b1;
        w_regWrite = 1'b1;
      end
      S_MEMWR: begin
        w_memReq   = 1'b1;
        w_memWrite = w_rdy;
      end
      S_EXEC: begin
        w_aluSrcA = 1'b1;
        w_aluCtl  = w_functAluCtl;
      end
      S_ALUWB: begin
        w_regDst   = 1'b1;
        w_regWrite = 1'b1;
      end
      S_BRANCH: begin
        w_aluSrcA  = 1'b1;
        w_aluCtl   = ALU_SUB;
        w_pcSrc    = 2'b01;
        w_branch   = (bus.op == OP_BEQ);
        w_branchNe = (bus.op == OP_BNE);
      end
      S_ADDIWB: w_regWrite = 1'b1;
      S_JUMP: begin
        w_pcSrc   = 2'b10;
        w_pcWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_pcEn = w_pcWrite | (w_branch & bus.zero) | (w_branchNe & ~bus.zero);

  // Write enables are masked during reset so an interrupted instruction
  // cannot leave a partial register, memory or PC update behind.
  assign bus.IRWrite    = w_irWrite  & ~reset;
  assign bus.PCEn       = w_pcEn     & ~reset;
  assign bus.RegWrite   = w_regWrite & ~reset;
  assign bus.MemWrite   = w_memWrite & ~reset;
  assign bus.mem_req    = w_memReq;
  assign bus.RegDst     = w_regDst;
  assign bus.MemtoReg   = w_memtoReg;
  assign bus.ALUSrcA    = w_aluSrcA;
  assign bus.ALUSrcB    = w_aluSrcB;
  assign bus.PCSrc      = w_pcSrc;
  assign bus.ALUControl = ALUCTL_W'(w_aluCtl);
  assign bus.p_state    = STATE_W'(r_state);
  assign bus.illegal    = r_illegal;
  assign bus.timeout    = r_timeout;

endmodule
